// File: rtl/ntr_pkg.sv
// ntr_pkg: definitions shared by the NTR command-capture block.
//   frame_state_e   - frame FSM state encoding
//   NTR_LED_OP_DEF  - default opcode (word 0) that marks an LED-write command
package ntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // cs1 high, no frame in progress
        ST_CAPTURE = 2'd1,  // cs1 low, collecting words
        ST_DONE    = 2'd2   // full command taken, waiting for cs1 to rise
    } frame_state_e;

    localparam logic [7:0] NTR_LED_OP_DEF = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
//   clk, rst     - clock, synchronous active-high reset (empties the queue)
//   push, din    - write request and data; ignored when full unless popping
//   pop          - read request; ignored when empty
//   dout         - head entry, valid while !empty
//   full, empty  - occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indexes match.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ntr_cmd_capture.sv
// ntr_cmd_capture: captures fixed-length commands from an NTR card bus and
// queues them for a consumer; an LED-write opcode also updates a LED register.
//   clk, rst          - system clock, synchronous active-high reset
//   ntr_clk, ntr_cs1  - debounced bus clock and active-low chip select
//   ntr_data          - bus data, one word per rising ntr_clk
//   cmd_data/valid/ready - head-of-queue command handshake (word 0 in LSBs)
//   byte_count        - words captured in the current frame
//   leds              - LED register
//   overflow          - sticky: a completed command was dropped (queue full)
//   short_frame       - sticky: cs1 rose before a full command arrived
module ntr_cmd_capture
    import ntr_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                CMD_BYTES  = 8,
    parameter int                FIFO_DEPTH = 4,
    parameter int                LED_W      = 4,
    parameter logic [DATA_W-1:0] LED_OP     = DATA_W'(NTR_LED_OP_DEF)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ntr_clk,
    input  logic                              ntr_cs1,
    input  logic [DATA_W-1:0]                 ntr_data,
    output logic [DATA_W*CMD_BYTES-1:0]       cmd_data,
    output logic                              cmd_valid,
    input  logic                              cmd_ready,
    output logic [$clog2(CMD_BYTES+1)-1:0]    byte_count,
    output logic [LED_W-1:0]                  leds,
    output logic                              overflow,
    output logic                              short_frame
);

    localparam int CNT_W = $clog2(CMD_BYTES+1);

    // ---- input sampling / strobe detect ----
    logic              clk_q, clk_prev, cs1_q, cs1_armed;
    logic [DATA_W-1:0] data_q;
    logic              strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_q     <= 1'b1;
            clk_prev  <= 1'b1;
            cs1_q     <= 1'b1;
            cs1_armed <= 1'b0;
            data_q    <= '0;
        end else begin
            clk_q     <= ntr_clk;
            clk_prev  <= clk_q;
            cs1_q     <= ntr_cs1;
            // Set once cs1 has really been seen high after reset; a frame
            // interrupted by reset is not resumed until cs1 falls afresh.
            cs1_armed <= cs1_armed | ntr_cs1;
            data_q    <= ntr_data;
        end
    end

    assign strobe = clk_q & ~clk_prev & ~cs1_q;

    // ---- frame FSM ----
    frame_state_e state_q, state_d;
    logic         cap_en, last, short_set, cnt_clr;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cap_en    = 1'b0;
        short_set = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (~cs1_q && cs1_armed) begin
                    state_d = ST_CAPTURE;
                    cap_en  = strobe;  // strobe coincident with cs1 falling still counts
                end
            end
            ST_CAPTURE: begin
                if (cs1_q) begin
                    state_d   = ST_IDLE;
                    cnt_clr   = 1'b1;
                    short_set = (byte_count != '0);
                end else begin
                    cap_en = strobe;
                end
            end
            ST_DONE: begin
                if (cs1_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        last = cap_en && (byte_count == CNT_W'(CMD_BYTES-1));
        if (last) state_d = ST_DONE;
    end

    // ---- assembly, counters, LED and status flags ----
    logic [CMD_BYTES-1:0][DATA_W-1:0] asm_q;
    logic                             done_q;   // one-cycle push strobe after the final word
    logic                             fifo_full, fifo_empty, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            byte_count  <= '0;
            done_q      <= 1'b0;
            leds        <= '0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            done_q <= last;
            for (int i = 0; i < CMD_BYTES; i++) begin
                if (cap_en && byte_count == CNT_W'(i)) asm_q[i] <= data_q;
            end
            if (last || cnt_clr) byte_count <= '0;
            else if (cap_en)     byte_count <= byte_count + CNT_W'(1);
            if (short_set) short_frame <= 1'b1;
            if (done_q && fifo_full && !pop) overflow <= 1'b1;
            // LED update does not depend on whether the queue accepted the command.
            if (done_q && asm_q[0] == LED_OP) leds <= asm_q[CMD_BYTES-1][LED_W-1:0];
        end
    end

    // ---- command queue ----
    assign cmd_valid = ~fifo_empty;
    assign pop       = cmd_valid & cmd_ready;

    sync_fifo #(
        .WIDTH (DATA_W*CMD_BYTES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done_q),
        .din   (asm_q),
        .pop   (pop),
        .dout  (cmd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_ntr_cmd_capture.sv
module tb_ntr_cmd_capture;

    logic        clk = 1'b0;
    logic        rst, ntr_clk, ntr_cs1, cmd_ready;
    logic [7:0]  ntr_data;
    logic [63:0] cmd_data;
    logic        cmd_valid, overflow, short_frame;
    logic [3:0]  byte_count, leds;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [63:0] exp_q[$];
    logic [3:0]  leds_m;
    logic        ovf_m, short_m;
    logic [7:0]  fb [16];

    ntr_cmd_capture dut (
        .clk         (clk),
        .rst         (rst),
        .ntr_clk     (ntr_clk),
        .ntr_cs1     (ntr_cs1),
        .ntr_data    (ntr_data),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .byte_count  (byte_count),
        .leds        (leds),
        .overflow    (overflow),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        leds_m  = '0;
        ovf_m   = 1'b0;
        short_m = 1'b0;
    endtask

    // Effect of a frame of n strobes with no pops during it.
    task automatic model_frame(input int n);
        logic [63:0] c;
        if (n >= 8) begin
            c = '0;
            for (int i = 0; i < 8; i++) c[i*8 +: 8] = fb[i];
            if (exp_q.size() < 4) exp_q.push_back(c);
            else                  ovf_m = 1'b1;
            if (fb[0] == 8'hFF) leds_m = fb[7][3:0];
        end else if (n > 0) begin
            short_m = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic cs_low();
        ntr_cs1 = 1'b0;
        tick(); tick();
    endtask

    task automatic cs_high();
        ntr_cs1 = 1'b1;
        tick(); tick(); tick();
    endtask

    // Returns one cycle after the strobe's capture edge.
    task automatic send_byte(input logic [7:0] d);
        ntr_data = d;
        ntr_clk  = 1'b0;
        tick(); tick();
        ntr_clk  = 1'b1;
        tick(); tick();
    endtask

    task automatic run_frame(input int n);
        cs_low();
        for (int i = 0; i < n; i++) send_byte(fb[i]);
        cs_high();
    endtask

    task automatic rand_fb();
        for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
        if ($urandom_range(1, 0) == 1) fb[0] = 8'hFF;
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    task automatic drain_check(input string nm);
        logic [63:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== e) begin
                errors++;
                $display("FAIL %s: valid=%b data=%h expected valid=1 data=%h", nm, cmd_valid, cmd_data, e);
            end
            pop_one();
        end
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty: cmd_valid=%b expected 0", nm, cmd_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", cmd_valid); end
        checks++;
        if (byte_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", byte_count); end
        checks++;
        if (leds !== 4'h0) begin errors++; $display("FAIL reset_leds: got %h exp 0", leds); end
        checks++;
        if (overflow !== 1'b0 || short_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: overflow=%b short=%b exp 0 0", overflow, short_frame);
        end
    endtask

    task automatic test_led_cmd();
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        fb[0] = 8'hFF;
        fb[7] = 8'h05;
        cs_low();
        for (int i = 0; i < 8; i++) send_byte(fb[i]);
        model_frame(8);
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL led_latency1: cmd_valid=%b exp 0", cmd_valid); end
        tick();
        checks++;
        if (cmd_valid !== 1'b1) begin errors++; $display("FAIL led_latency2: cmd_valid=%b exp 1", cmd_valid); end
        checks++;
        if (cmd_data[7:0] !== 8'hFF) begin errors++; $display("FAIL led_word0: got %h exp FF", cmd_data[7:0]); end
        checks++;
        if (leds !== 4'h5 || leds !== leds_m) begin errors++; $display("FAIL led_value: got %h exp %h", leds, leds_m); end
        cs_high();
        drain_check("led_cmd");
    endtask

    task automatic test_short_frame();
        rand_fb();
        fb[0] = 8'hFF;
        cs_low();
        for (int i = 0; i < 3; i++) send_byte(fb[i]);
        checks++;
        if (byte_count !== 4'd3) begin errors++; $display("FAIL short_count3: got %0d exp 3", byte_count); end
        cs_high();
        model_frame(3);
        checks++;
        if (short_frame !== short_m) begin errors++; $display("FAIL short_flag: got %b exp %b", short_frame, short_m); end
        checks++;
        if (byte_count !== 4'd0) begin errors++; $display("FAIL short_count0: got %0d exp 0", byte_count); end
        checks++;
        if (cmd_valid !== 1'b0) begin errors++; $display("FAIL short_nopush: cmd_valid=%b exp 0", cmd_valid); end
        checks++;
        if (leds !== leds_m) begin errors++; $display("FAIL short_leds: got %h exp %h", leds, leds_m); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) begin
            rand_fb();
            run_frame(8);
            model_frame(8);
            checks++;
            if (overflow !== ovf_m) begin
                errors++;
                $display("FAIL ovf_flag%0d: got %b exp %b", k, overflow, ovf_m);
            end
            checks++;
            if (leds !== leds_m) begin errors++; $display("FAIL ovf_leds%0d: got %h exp %h", k, leds, leds_m); end
        end
        drain_check("ovf_order");
    endtask

    task automatic test_full_pop();
        logic [63:0] c;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rand_fb();
            run_frame(8);
            model_frame(8);
        end
        rand_fb();
        cs_low();
        for (int i = 0; i < 8; i++) send_byte(fb[i]);
        // now in the push cycle: pop the head concurrently
        checks++;
        if (cmd_data !== exp_q[0]) begin errors++; $display("FAIL fullpop_head: got %h exp %h", cmd_data, exp_q[0]); end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        void'(exp_q.pop_front());
        c = '0;
        for (int i = 0; i < 8; i++) c[i*8 +: 8] = fb[i];
        exp_q.push_back(c);
        if (fb[0] == 8'hFF) leds_m = fb[7][3:0];
        cs_high();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: got %b exp 0", overflow); end
        checks++;
        if (leds !== leds_m) begin errors++; $display("FAIL fullpop_leds: got %h exp %h", leds, leds_m); end
        drain_check("fullpop_order");
    endtask

    task automatic test_done_and_reset();
        rand_fb();
        run_frame(9);
        model_frame(9);
        checks++;
        if (byte_count !== 4'd0) begin errors++; $display("FAIL done_count: got %0d exp 0", byte_count); end
        checks++;
        if (short_frame !== short_m) begin errors++; $display("FAIL done_short: got %b exp %b", short_frame, short_m); end
        drain_check("done_ignore");
        // reset mid-frame with cs1 held low
        rand_fb();
        cs_low();
        for (int i = 0; i < 4; i++) send_byte(fb[i]);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        model_reset();
        checks++;
        if (byte_count !== 4'd0) begin errors++; $display("FAIL rst_mid_count: got %0d exp 0", byte_count); end
        for (int i = 4; i < 6; i++) send_byte(fb[i]);
        checks++;
        if (byte_count !== 4'd0) begin errors++; $display("FAIL rst_no_resume: got %0d exp 0", byte_count); end
        cs_high();
        checks++;
        if (short_frame !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_clean: short=%b valid=%b exp 0 0", short_frame, cmd_valid);
        end
        rand_fb();
        run_frame(8);
        model_frame(8);
        drain_check("rst_next_frame");
    endtask

    task automatic test_cs_high_toggle();
        ntr_cs1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'($urandom));
            checks++;
            if (byte_count !== 4'd0 || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL cs_high_toggle%0d: count=%0d valid=%b exp 0 0", k, byte_count, cmd_valid);
            end
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rand_fb();
            n = $urandom_range(10, 1);
            run_frame(n);
            model_frame(n);
            checks++;
            if (short_frame !== short_m || leds !== leds_m || overflow !== ovf_m) begin
                errors++;
                $display("FAIL rand_state%0d: short=%b leds=%h ovf=%b exp %b %h %b",
                         k, short_frame, leds, overflow, short_m, leds_m, ovf_m);
            end
            drain_check("rand_cmd");
        end
    endtask

    initial begin
        rst       = 1'b1;
        ntr_clk   = 1'b0;
        ntr_cs1   = 1'b1;
        ntr_data  = '0;
        cmd_ready = 1'b0;
        model_reset();
        test_reset();
        test_led_cmd();
        test_short_frame();
        test_overflow();
        test_full_pop();
        test_done_and_reset();
        test_cs_high_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ntr_cmd_capture.md
NTR_CMD_CAPTURE -- requirements
Module: ntr_cmd_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, NTR data bus width in bits.
REQ-002 SHALL have parameter CMD_BYTES, default 8, bus words per command.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, queued commands; power of two, >=2.
REQ-004 SHALL have parameter LED_W, default 4, LED register width; LED_W <= DATA_W.
REQ-005 SHALL have parameter LED_OP, default 8'hFF, opcode selecting an LED write.
REQ-006 SHALL have port clk, input, 1, system clock; the only clock.
REQ-007 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port ntr_clk, input, 1, debounced NTR bus clock, sampled in clk.
REQ-009 SHALL have port ntr_cs1, input, 1, debounced chip select, active low.
REQ-010 SHALL have port ntr_data, input, DATA_W, NTR data bus.
REQ-011 SHALL have port cmd_data, output, DATA_W*CMD_BYTES, head-of-queue command.
REQ-012 SHALL have port cmd_valid, output, 1, cmd_data holds a queued command.
REQ-013 SHALL have port cmd_ready, input, 1, consumer accepts cmd_data.
REQ-014 SHALL have port byte_count, output, $clog2(CMD_BYTES+1), words captured in current frame.
REQ-015 SHALL have port leds, output, LED_W, LED register.
REQ-016 SHALL have port overflow, output, 1, sticky: a command was dropped because the queue was full.
REQ-017 SHALL have port short_frame, output, 1, sticky: cs1 rose before a full command.

Function
REQ-018 SHALL register ntr_clk and ntr_cs1 once in clk; a capture strobe is a 0->1 transition of registered ntr_clk while registered ntr_cs1 is 0.
REQ-019 SHALL on each strobe store ntr_data, registered alongside ntr_clk, into word byte_count; word 0 occupies bits [DATA_W-1:0], word i bits [i*DATA_W +: DATA_W].
REQ-020 SHALL increment byte_count per strobe; on strobe CMD_BYTES, push the assembled command into the FIFO the next cycle and clear byte_count to 0.
REQ-021 SHALL use frame FSM states IDLE (cs1 high), CAPTURE (cs1 low, count<CMD_BYTES), DONE (command complete, cs1 still low).
REQ-022 SHALL ignore strobes in DONE; cs1 high returns to IDLE with byte_count 0.
REQ-023 SHALL, on cs1 rising in CAPTURE with 0<byte_count<CMD_BYTES, discard the partial frame, set short_frame, and clear byte_count.
REQ-024 SHALL present cmd_valid high whenever the FIFO is non-empty; a pop occurs on cmd_valid & cmd_ready.
REQ-025 SHALL, on push to a full FIFO with no same-cycle pop, drop the new command and set overflow; push and pop in the same cycle on a full FIFO both succeed.
REQ-026 SHALL give a capture-to-cmd_valid latency of 2 clk after the final strobe when the FIFO is empty.
REQ-027 SHALL, when a completed command has word 0 equal to LED_OP, load leds from bits [LED_W-1:0] of word CMD_BYTES-1, one cycle after completion, regardless of FIFO fullness.
REQ-028 SHALL keep cmd_data stable while cmd_valid is high and cmd_ready is low.
REQ-029 SHALL clear overflow and short_frame only on rst.

Reset
REQ-030 SHALL on rst: FIFO empty, cmd_valid 0, byte_count 0, leds 0, overflow 0, short_frame 0, FSM IDLE, edge-detect registers 1.
REQ-031 SHALL, for rst asserted mid-frame, discard the partial frame and require a new cs1 falling edge before capture resumes.

Structure
REQ-032 SHALL place FSM state encodings and the LED_OP default in shared package ntr_pkg.
REQ-033 SHALL implement the queue as sub-module sync_fifo (parametrised width and depth; full, empty, push, pop).

Verification
REQ-034 SHALL cover: cs1 low, 8 strobes with bytes FF,00..00,05 -> cmd_valid after 2 clk, cmd_data[7:0]=FF, leds=4'h5.
REQ-035 SHALL cover: cs1 high after 3 strobes -> short_frame=1, byte_count=0, no push, leds unchanged.
REQ-036 SHALL cover: 5 commands with cmd_ready=0, depth 4 -> 4 queued in order, overflow=1, 5th lost.
REQ-037 SHALL cover: full FIFO, cmd_ready=1 in completion cycle -> no overflow, order preserved.
REQ-038 SHALL cover: 9th strobe in DONE -> ignored; rst after 4 strobes -> byte_count=0, next frame captured cleanly.
REQ-039 SHALL cover: ntr_clk toggling with cs1 high -> no capture, byte_count stays 0.
